// File: rtl/trace_session_pkg.sv
// Shared types and constants for the trace session controller.
package trace_session_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_TRACING = 3'd2,
        S_FLUSH   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] WFI_INSTR  = 32'h0000_0001;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam int          CNT_WIDTH_DEFAULT = 32;

    function automatic logic is_ctrl_flow(input logic [31:0] ins);
        return (ins[6:0] == OPC_JAL) || (ins[6:0] == OPC_JALR) || (ins[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/trace_session_controller.sv
// Armed, address-triggered trace session sequencer with tlast framing and packet/drop counters.
// Optional build macro CMS_TRACE_FILTER_EN restricts traced candidates to control-flow instructions.
module trace_session_controller
    import trace_session_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_arm,
    input  logic                 cfg_abort,
    input  logic [XLEN-1:0]      cfg_start_addr,
    input  logic [XLEN-1:0]      cfg_end_addr,
    input  logic [CNT_WIDTH-1:0] cfg_tlast_interval,
    input  logic [XLEN-1:0]      pc,
    input  logic [31:0]          instr,
    input  logic                 pc_valid,
    input  logic                 sink_ready,
    output logic                 trace_we,
    output logic [XLEN-1:0]      trace_pc,
    output logic [31:0]          trace_instr,
    output logic                 trace_last,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   frame_q, frame_d;
    logic [XLEN-1:0]        term_pc_q;
    logic [31:0]            term_instr_q;

    logic                   active, is_term, is_cand;
    logic                   emit, emit_term, emit_last, drop, clr, latch;
    logic [XLEN-1:0]        emit_pc;
    logic [31:0]            emit_instr;

    // An instruction is looked at only on the start match in ARMED or any valid beat in TRACING.
    assign active  = pc_valid && ((state_q == S_TRACING) ||
                                  (state_q == S_ARMED && pc == cfg_start_addr));
    assign is_term = (pc == cfg_end_addr) || (instr == WFI_INSTR);

`ifdef CMS_TRACE_FILTER_EN
    assign is_cand = is_term || (state_q == S_ARMED) || is_ctrl_flow(instr);
`else
    assign is_cand = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        emit       = 1'b0;
        emit_term  = 1'b0;
        drop       = 1'b0;
        clr        = 1'b0;
        latch      = 1'b0;
        emit_pc    = pc;
        emit_instr = instr;
        if (cfg_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_arm) begin
                        state_d = S_ARMED;
                        clr     = 1'b1;
                    end
                end
                S_ARMED, S_TRACING: begin
                    if (active && is_cand) begin
                        state_d = S_TRACING;
                        if (is_term) begin
                            if (sink_ready) begin
                                emit      = 1'b1;
                                emit_term = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                latch   = 1'b1;
                                state_d = S_FLUSH;
                            end
                        end else begin
                            emit = sink_ready;
                            drop = !sink_ready;
                        end
                    end
                end
                S_FLUSH: begin
                    drop       = pc_valid;
                    emit_pc    = term_pc_q;
                    emit_instr = term_instr_q;
                    if (sink_ready) begin
                        emit      = 1'b1;
                        emit_term = 1'b1;
                        state_d   = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame position advances only on emitted packets; interval 0 never marks on its own.
    always_comb begin
        frame_d   = frame_q;
        emit_last = 1'b0;
        if (clr) begin
            frame_d = '0;
        end else if (emit) begin
            if (emit_term) begin
                emit_last = 1'b1;
                frame_d   = '0;
            end else if (cfg_tlast_interval != '0) begin
                if (frame_q == cfg_tlast_interval - CNT_WIDTH'(1)) begin
                    emit_last = 1'b1;
                    frame_d   = '0;
                end else begin
                    frame_d = frame_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            term_pc_q    <= '0;
            term_instr_q <= '0;
            trace_we     <= 1'b0;
            trace_last   <= 1'b0;
            trace_pc     <= '0;
            trace_instr  <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            trace_we   <= emit;
            trace_last <= emit_last;
            if (latch) begin
                term_pc_q    <= pc;
                term_instr_q <= instr;
            end
            if (emit) begin
                trace_pc    <= emit_pc;
                trace_instr <= emit_instr;
            end
        end
    end

    assign state = state_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (emit),
        .count (pkt_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (drop),
        .count (drop_count)
    );

endmodule

// File: tb/tb_trace_session_controller.sv
// Directed bench for trace_session_controller: session-level reference model plus literal checks.
module tb_trace_session_controller;

    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_ADD  = 32'h0000_0033;
    localparam logic [31:0] I_ADDI = 32'h0000_0013;
    localparam logic [31:0] I_WFI  = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_arm = 1'b0, cfg_abort = 1'b0;
    logic [63:0] cfg_start_addr = '0, cfg_end_addr = '0;
    logic [31:0] cfg_tlast_interval = '0;
    logic [63:0] pc = '0;
    logic [31:0] instr = '0;
    logic        pc_valid = 1'b0, sink_ready = 1'b0;
    logic        trace_we, trace_last;
    logic [63:0] trace_pc;
    logic [31:0] trace_instr;
    logic [2:0]  state;
    logic [31:0] pkt_count, drop_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] got_pc[$];
    logic        got_last[$];

    always #5 clk = ~clk;

    trace_session_controller #(.XLEN(64), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .cfg_tlast_interval(cfg_tlast_interval), .pc(pc), .instr(instr),
        .pc_valid(pc_valid), .sink_ready(sink_ready), .trace_we(trace_we),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_last(trace_last),
        .state(state), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    // Session phases: 0 idle, 1 waiting for start, 2 tracing, 3 holding terminator, 4 done.
    typedef struct packed {
        logic [2:0]  ph;
        logic        we;
        logic        last;
        logic [63:0] pc;
        logic [31:0] ins;
        logic [31:0] pkt;
        logic [31:0] drp;
        logic [31:0] pos;
        logic [63:0] tpc;
        logic [31:0] tins;
    } mdl_t;

    mdl_t m;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic bit traced_kind(input logic [31:0] ins);
`ifdef CMS_TRACE_FILTER_EN
        return ins[6:0] == 7'h6F || ins[6:0] == 7'h67 || ins[6:0] == 7'h63;
`else
        return 1'b1;
`endif
    endfunction

    function automatic mdl_t step(input mdl_t cur);
        mdl_t n = cur;
        bit   term, send, mark;
        logic [63:0] spc;
        logic [31:0] sins;
        n.we = 1'b0;
        n.last = 1'b0;
        send = 1'b0;
        term = 1'b0;
        spc = pc;
        sins = instr;
        if (cfg_abort) begin
            n.ph = 3'd0;
            return n;
        end
        if (cur.ph == 3'd0 || cur.ph == 3'd4) begin
            if (cfg_arm) begin
                n.ph = 3'd1; n.pkt = '0; n.drp = '0; n.pos = '0;
            end
            return n;
        end
        if (cur.ph == 3'd3) begin
            if (pc_valid) n.drp = sat_inc(cur.drp);
            if (!sink_ready) return n;
            send = 1'b1; term = 1'b1; spc = cur.tpc; sins = cur.tins; n.ph = 3'd4;
        end else begin
            if (!pc_valid) return n;
            if (cur.ph == 3'd1 && pc != cfg_start_addr) return n;
            term = (pc == cfg_end_addr) || (instr == 32'h1);
            if (!(term || cur.ph == 3'd1 || traced_kind(instr))) return n;
            n.ph = 3'd2;
            if (!sink_ready) begin
                if (term) begin
                    n.ph = 3'd3; n.tpc = pc; n.tins = instr;
                end else begin
                    n.drp = sat_inc(cur.drp);
                end
                return n;
            end
            send = 1'b1;
            if (term) n.ph = 3'd4;
        end
        if (send) begin
            mark = term;
            if (term) n.pos = '0;
            else if (cfg_tlast_interval != 0) begin
                if (cur.pos + 32'd1 == cfg_tlast_interval) begin
                    mark = 1'b1; n.pos = '0;
                end else n.pos = cur.pos + 32'd1;
            end
            n.we = 1'b1; n.last = mark; n.pc = spc; n.ins = sins;
            n.pkt = sat_inc(cur.pkt);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", 64'(state), 64'(m.ph));
            chk("trace_we", 64'(trace_we), 64'(m.we));
            chk("trace_last", 64'(trace_last), 64'(m.last));
            chk("pkt_count", 64'(pkt_count), 64'(m.pkt));
            chk("drop_count", 64'(drop_count), 64'(m.drp));
            if (m.we) begin
                chk("trace_pc", trace_pc, m.pc);
                chk("trace_instr", 64'(trace_instr), 64'(m.ins));
            end
            if (trace_we) begin
                got_pc.push_back(trace_pc);
                got_last.push_back(trace_last);
            end
        end
    end

    task automatic drive(input bit a, input bit ab, input bit v, input logic [63:0] p,
                         input logic [31:0] i, input bit r);
        cfg_arm = a; cfg_abort = ab; pc_valid = v; pc = p; instr = i; sink_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 64'h0, 32'h0, 1);
    endtask

    initial begin
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_pkt", 64'(pkt_count), 64'd0);

        // Start/stop
        cfg_start_addr = 64'h1000; cfg_end_addr = 64'h1010; cfg_tlast_interval = 0;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) drive(0, 0, 1, 64'h0FF8 + 64'(4 * k), I_JAL, 1);
        idle();
        chk("t1_npkt", 64'(got_pc.size()), 64'd5);
        chk("t1_first_pc", got_pc[0], 64'h1000);
        chk("t1_last_pc", got_pc[4], 64'h1010);
        chk("t1_last_flag", 64'(got_last[4]), 64'd1);
        chk("t1_mid_flag", 64'(got_last[3]), 64'd0);
        chk("t1_state", 64'(state), 64'd4);
        chk("t1_pkt", 64'(pkt_count), 64'd5);

        // Interval framing, then abort together with arm
        cfg_end_addr = 64'hFFFF_FFFF_FFFF_F000; cfg_tlast_interval = 3;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) drive(0, 0, 1, 64'h1000 + 64'(4 * k), I_JAL, 1);
        idle();
        chk("t2_npkt", 64'(got_pc.size()), 64'd8);
        chk("t2_last3", 64'(got_last[2]), 64'd1);
        chk("t2_last6", 64'(got_last[5]), 64'd1);
        chk("t2_nolast4", 64'(got_last[3]), 64'd0);
        chk("t2_nolast8", 64'(got_last[7]), 64'd0);
        chk("t2_pkt", 64'(pkt_count), 64'd8);
        chk("t2_drop", 64'(drop_count), 64'd0);
        chk("t2_tracing", 64'(state), 64'd2);
        drive(1, 1, 1, 64'h1020, I_JAL, 1);
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_we", 64'(trace_we), 64'd0);
        chk("abort_pkt_held", 64'(pkt_count), 64'd8);
        idle();

        // Backpressure and flush
        cfg_start_addr = 64'h1000; cfg_end_addr = 64'h1018; cfg_tlast_interval = 0;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 64'h1000, I_JAL, 1);
        drive(0, 0, 1, 64'h1004, I_JAL, 0);
        drive(0, 0, 1, 64'h1008, I_JAL, 1);
        drive(0, 0, 1, 64'h100C, I_JAL, 1);
        drive(0, 0, 1, 64'h1010, I_JAL, 0);
        drive(0, 0, 1, 64'h1014, I_JAL, 1);
        chk("t3_drop2", 64'(drop_count), 64'd2);
        drive(0, 0, 1, 64'h1018, I_JAL, 0);
        chk("t3_flush", 64'(state), 64'd3);
        drive(0, 0, 1, 64'h101C, I_JAL, 0);
        chk("t3_drop3", 64'(drop_count), 64'd3);
        drive(0, 0, 0, 64'h0, 32'h0, 1);
        idle();
        chk("t3_npkt", 64'(got_pc.size()), 64'd5);
        chk("t3_term_pc", got_pc[4], 64'h1018);
        chk("t3_term_last", 64'(got_last[4]), 64'd1);
        chk("t3_state", 64'(state), 64'd4);
        chk("t3_pkt", 64'(pkt_count), 64'd4 + 64'd1);

        // Same-cycle start/end, then WFI terminator
        cfg_start_addr = 64'h2000; cfg_end_addr = 64'h2000;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 64'h2000, I_JAL, 1);
        idle();
        chk("t4_single", 64'(got_pc.size()), 64'd1);
        chk("t4_single_last", 64'(got_last[0]), 64'd1);
        chk("t4_done", 64'(state), 64'd4);
        cfg_start_addr = 64'h3000; cfg_end_addr = 64'hFFFF_0000;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 64'h3000, I_JAL, 1);
        drive(0, 0, 1, 64'h3004, I_JAL, 1);
        drive(0, 0, 1, 64'h3008, I_JAL, 1);
        drive(0, 0, 1, 64'h300C, I_WFI, 1);
        idle();
        chk("t4_wfi_npkt", 64'(got_pc.size()), 64'd4);
        chk("t4_wfi_pc", got_pc[3], 64'h300C);
        chk("t4_wfi_last", 64'(got_last[3]), 64'd1);
        chk("t4_wfi_state", 64'(state), 64'd4);

        // Asynchronous reset mid-session
        cfg_start_addr = 64'h4000; cfg_end_addr = 64'hFFFF_0000;
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 64'h4000, I_JAL, 1);
        drive(0, 0, 1, 64'h4004, I_JAL, 1);
        chk("t5_pre_we", 64'(trace_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 64'(trace_we), 64'd0);
        chk("t5_rst_last", 64'(trace_last), 64'd0);
        chk("t5_rst_state", 64'(state), 64'd0);
        chk("t5_rst_pc", trace_pc, 64'd0);
        chk("t5_rst_instr", 64'(trace_instr), 64'd0);
        chk("t5_rst_pkt", 64'(pkt_count), 64'd0);
        chk("t5_rst_drop", 64'(drop_count), 64'd0);
        pc_valid = 1'b0;
        #2 rst_n = 1'b1;
        idle();

        // Control-flow filtering
        cfg_start_addr = 64'h5000; cfg_end_addr = 64'h5014;
        got_pc.delete(); got_last.delete();
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 64'h5000, I_ADD, 1);
        drive(0, 0, 1, 64'h5004, I_JAL, 1);
        drive(0, 0, 1, 64'h5008, I_ADDI, 1);
        drive(0, 0, 1, 64'h500C, I_BEQ, 1);
        drive(0, 0, 1, 64'h5010, I_JALR, 1);
        drive(0, 0, 1, 64'h5014, I_ADD, 1);
        idle();
`ifdef CMS_TRACE_FILTER_EN
        chk("t6_npkt", 64'(got_pc.size()), 64'd5);
        chk("t6_pc2", got_pc[2], 64'h500C);
`else
        chk("t6_npkt", 64'(got_pc.size()), 64'd6);
        chk("t6_pc2", got_pc[2], 64'h5008);
`endif
        chk("t6_drop", 64'(drop_count), 64'd0);
        chk("t6_end_last", 64'(got_last[got_pc.size() - 1]), 64'd1);
        chk("t6_state", 64'(state), 64'd4);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
